// File: rtl/relay_sequencer.sv
// Staged relay power sequencer: pulls relays in one at a time with contact
// confirmation and settle time, drops them in reverse order, and latches timeouts.
`timescale 1ns/1ps

module relay_sequencer #(
    parameter int N     = 4,
    parameter int TMO   = 40,
    parameter int DWELL = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clr,
    input  logic [N-1:0]         c,
    output logic [N-1:0]         e,
    output logic [N-1:0]         ar,
    output logic                 ready,
    output logic                 busy,
    output logic                 fault,
    output logic [$clog2(N)-1:0] stage
);

    localparam int KW   = $clog2(N);
    localparam int CMAX = (TMO > DWELL) ? TMO : DWELL;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
    localparam logic [KW-1:0] K_ZERO  = '0;
    localparam logic [KW-1:0] K_ONE   = KW'(1);
    localparam logic [CW-1:0] C_TMO   = CW'(TMO);
    localparam logic [CW-1:0] C_DWELL = CW'(DWELL);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULL,
        S_DWELL,
        S_ON,
        S_DROP,
        S_FAULT
    } state_t;

    state_t          state_reg, state_next;
    logic [KW-1:0]   k_reg, k_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            expire;
    logic            fb;

    // A timeout is the tick that would take the counter from 1 to 0.
    assign expire = tick && (cnt_reg == C_ONE);
    assign fb     = c[k_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            k_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        cnt_next   = (tick && (cnt_reg != '0)) ? (cnt_reg - C_ONE) : cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (start && !stop) begin
                    state_next = S_PULL;
                    k_next     = K_ZERO;
                    cnt_next   = C_TMO;
                end
            end
            S_PULL: begin
                // Feedback beats a coincident timeout; a real timeout beats stop.
                if (!fb && expire) begin
                    state_next = S_FAULT;
                end else if (stop) begin
                    state_next = S_DROP;
                    cnt_next   = C_TMO;
                end else if (fb) begin
                    state_next = S_DWELL;
                    cnt_next   = C_DWELL;
                end
            end
            S_DWELL: begin
                if (stop) begin
                    state_next = S_DROP;
                    cnt_next   = C_TMO;
                end else if (expire) begin
                    if (k_reg == K_LAST) begin
                        state_next = S_ON;
                    end else begin
                        state_next = S_PULL;
                        k_next     = k_reg + K_ONE;
                        cnt_next   = C_TMO;
                    end
                end
            end
            S_ON: begin
                if (stop) begin
                    state_next = S_DROP;
                    k_next     = K_LAST;
                    cnt_next   = C_TMO;
                end
            end
            S_DROP: begin
                if (!fb) begin
                    if (k_reg == K_ZERO) begin
                        state_next = S_IDLE;
                    end else begin
                        k_next   = k_reg - K_ONE;
                        cnt_next = C_TMO;
                    end
                end else if (expire) begin
                    state_next = S_FAULT;
                end
            end
            S_FAULT: begin
                if (clr) begin
                    state_next = S_IDLE;
                    k_next     = K_ZERO;
                end
            end
            default: begin
                state_next = S_IDLE;
                k_next     = K_ZERO;
                cnt_next   = '0;
            end
        endcase
    end

    assign ready = (state_reg == S_ON);
    assign busy  = (state_reg == S_PULL) || (state_reg == S_DWELL) || (state_reg == S_DROP);
    assign fault = (state_reg == S_FAULT);
    assign stage = busy ? k_reg : '0;

    // Coil k is held through PULL/DWELL at k, released first when dropping stage k.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_coil
            localparam logic [KW-1:0] GI = KW'(gi);
            assign e[gi]  = (state_reg == S_ON)
                         || (((state_reg == S_PULL) || (state_reg == S_DWELL)) && (GI <= k_reg))
                         || ((state_reg == S_DROP) && (GI < k_reg));
            assign ar[gi] = (state_reg == S_FAULT);
        end
    endgenerate

endmodule

// File: tb/tb_relay_sequencer.sv
// Self-checking bench for relay_sequencer: relay contact models, a behavioural
// reference of the sequencing rules, directed corner cases and a random soak.
`timescale 1ns/1ps

module tb_relay_sequencer;

    localparam int N     = 4;
    localparam int TMO   = 40;
    localparam int DWELL = 2;
    localparam int SW    = $clog2(N);

    localparam int M_IDLE  = 0;
    localparam int M_PULL  = 1;
    localparam int M_DWELL = 2;
    localparam int M_ON    = 3;
    localparam int M_DROP  = 4;
    localparam int M_FAULT = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          clr = 1'b0;
    logic [N-1:0]  c = '0;
    logic [N-1:0]  e;
    logic [N-1:0]  ar;
    logic          ready;
    logic          busy;
    logic          fault;
    logic [SW-1:0] stage;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int m_ph  = M_IDLE;
    int m_k   = 0;
    int m_cnt = 0;

    // relay contact models
    bit           cl[N];
    int           pc[N];
    int           oc[N];
    int           pull_t[N];
    int           rel_t[N];
    logic [N-1:0] stuck_open   = '0;
    logic [N-1:0] stuck_closed = '0;

    relay_sequencer #(.N(N), .TMO(TMO), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .start (start),
        .stop  (stop),
        .clr   (clr),
        .c     (c),
        .e     (e),
        .ar    (ar),
        .ready (ready),
        .busy  (busy),
        .fault (fault),
        .stage (stage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [N-1:0] model_e();
        int v;
        case (m_ph)
            M_PULL, M_DWELL: v = (1 << (m_k + 1)) - 1;
            M_ON:            v = (1 << N) - 1;
            M_DROP:          v = (1 << m_k) - 1;
            default:         v = 0;
        endcase
        return N'(v);
    endfunction

    function automatic logic [N-1:0] contacts();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = cl[i];
        return (r | stuck_closed) & ~stuck_open;
    endfunction

    task automatic relay_reset();
        for (int i = 0; i < N; i++) begin
            cl[i] = 1'b0;
            pc[i] = 0;
            oc[i] = 0;
        end
    endtask

    // Contacts close after pull_t ticks of coil drive and open after rel_t ticks without it.
    task automatic relay_tick(input logic [N-1:0] coil, input logic tk);
        for (int i = 0; i < N; i++) begin
            if (coil[i]) begin
                oc[i] = 0;
                if (!cl[i] && tk) begin
                    pc[i]++;
                    if (pc[i] >= pull_t[i]) cl[i] = 1'b1;
                end
            end else begin
                pc[i] = 0;
                if (cl[i] && tk) begin
                    oc[i]++;
                    if (oc[i] >= rel_t[i]) cl[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_ph  = M_IDLE;
        m_k   = 0;
        m_cnt = 0;
    endtask

    task automatic model_clock();
        int nph, nk, ncnt;
        bit tmo, fbk;
        nph  = m_ph;
        nk   = m_k;
        ncnt = (tick && m_cnt > 0) ? m_cnt - 1 : m_cnt;
        tmo  = tick && (m_cnt == 1);
        fbk  = c[m_k];
        case (m_ph)
            M_IDLE:  if (start && !stop) begin nph = M_PULL; nk = 0; ncnt = TMO; end
            M_PULL: begin
                if (!fbk && tmo)  nph = M_FAULT;
                else if (stop)    begin nph = M_DROP; ncnt = TMO; end
                else if (fbk)     begin nph = M_DWELL; ncnt = DWELL; end
            end
            M_DWELL: begin
                if (stop)         begin nph = M_DROP; ncnt = TMO; end
                else if (tmo) begin
                    if (m_k == N - 1) nph = M_ON;
                    else begin nph = M_PULL; nk = m_k + 1; ncnt = TMO; end
                end
            end
            M_ON:    if (stop) begin nph = M_DROP; nk = N - 1; ncnt = TMO; end
            M_DROP: begin
                if (!fbk) begin
                    if (m_k == 0) nph = M_IDLE;
                    else begin nk = m_k - 1; ncnt = TMO; end
                end else if (tmo) nph = M_FAULT;
            end
            M_FAULT: if (clr) begin nph = M_IDLE; nk = 0; end
            default: nph = M_IDLE;
        endcase
        m_ph  = nph;
        m_k   = nk;
        m_cnt = ncnt;
    endtask

    task automatic check_outputs();
        bit in_seq;
        in_seq = (m_ph == M_PULL) || (m_ph == M_DWELL) || (m_ph == M_DROP);
        chk("e", 32'(e), 32'(model_e()));
        chk("ar", 32'(ar), (m_ph == M_FAULT) ? 32'((1 << N) - 1) : 32'd0);
        chk("ready", 32'(ready), 32'(m_ph == M_ON));
        chk("busy", 32'(busy), 32'(in_seq));
        chk("fault", 32'(fault), 32'(m_ph == M_FAULT));
        chk("stage", 32'(stage), in_seq ? 32'(m_k) : 32'd0);
    endtask

    // One clock: advance models on the edge, check outputs 1 ns later, then drive contacts.
    task automatic step();
        logic [N-1:0] coil;
        @(posedge clk);
        coil = model_e();
        if (rst) begin
            model_reset();
            relay_reset();
        end else begin
            relay_tick(coil, tick);
            model_clock();
        end
        #1;
        check_outputs();
        c = contacts();
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            pull_t[i] = 10;
            rel_t[i]  = 3;
        end
        relay_reset();

        // reset state
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        tick = 1'b1;
        step();

        // start together with stop stays idle
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle_busy", 32'(busy), 32'd0);

        // nominal power-up
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pull0_e", 32'(e), 32'h1);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin step(); n++; end
        chk("powerup_latency", 32'(n), 32'd52);
        chk("powerup_e", 32'(e), 32'hF);

        // stop from ON
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("drop3_e", 32'(e), 32'h7);
        n = 0;
        while (busy === 1'b1 && n < 100) begin step(); n++; end
        chk("drop_latency", 32'(n), 32'd16);
        chk("drop_done_e", 32'(e), 32'h0);

        // pull timeout on stage 2
        stuck_open = 4'b0100;
        c = contacts();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (fault !== 1'b1 && n < 200) begin step(); n++; end
        chk("pull_timeout_latency", 32'(n), 32'd66);
        chk("fault_ar", 32'(ar), 32'hF);
        start = 1'b1;
        for (int i = 0; i < 3; i++) step();
        start = 1'b0;
        chk("fault_ignores_start", 32'(fault), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_to_idle_fault", 32'(fault), 32'd0);
        chk("clr_to_idle_ar", 32'(ar), 32'd0);
        stuck_open = '0;
        for (int i = 0; i < 10; i++) step();

        // feedback on the same clk as the final pull timeout tick
        stuck_open = 4'b0010;
        c = contacts();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(m_ph == M_PULL && m_k == 1 && m_cnt == 1) && n < 100) begin step(); n++; end
        stuck_open = '0;
        cl[1] = 1'b1;
        c = contacts();
        step();
        chk("coll_fb_fault", 32'(fault), 32'd0);
        chk("coll_fb_stage", 32'(stage), 32'd1);
        chk("coll_fb_busy", 32'(busy), 32'd1);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin step(); n++; end
        chk("coll_reach_on", 32'(ready), 32'd1);

        // stop on the same clk as a DROP timeout
        stuck_closed = 4'b1000;
        c = contacts();
        stop = 1'b1;
        step();
        stop = 1'b0;
        n = 0;
        while (!(m_ph == M_DROP && m_cnt == 1) && n < 100) begin step(); n++; end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("coll_stop_tmo_fault", 32'(fault), 32'd1);
        chk("coll_stop_tmo_e", 32'(e), 32'h0);
        clr = 1'b1; stop = 1'b1;
        step();
        clr = 1'b0; stop = 1'b0;
        chk("clr_with_stop_idle", 32'(fault), 32'd0);
        stuck_closed = '0;
        for (int i = 0; i < 10; i++) step();

        // asynchronous reset in DWELL at k=2
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(m_ph == M_DWELL && m_k == 2) && n < 100) begin step(); n++; end
        chk("pre_rst_e", 32'(e), 32'h7);
        rst = 1'b1;
        #1;
        chk("rst_async_e", 32'(e), 32'h0);
        chk("rst_async_flags", {29'd0, ready, busy, fault}, 32'd0);
        chk("rst_async_stage", 32'(stage), 32'd0);
        model_reset();
        relay_reset();
        c = contacts();
        step();
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_stage", 32'(stage), 32'd0);
        chk("restart_e", 32'(e), 32'h1);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin step(); n++; end
        chk("restart_on", 32'(ready), 32'd1);

        // random soak against the reference model
        for (int i = 0; i < N; i++) begin
            pull_t[i] = $urandom_range(2, 12);
            rel_t[i]  = $urandom_range(1, 5);
        end
        for (int i = 0; i < 3000; i++) begin
            tick  = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 49) == 0);
            clr   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) stuck_open[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 399) == 0) stuck_closed[$urandom_range(0, N - 1)] ^= 1'b1;
            c = contacts();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
